// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// ALU operation codes (shared with the ALU), opcode/funct values and the
// datapath select encodings.
package mc_pkg;

  // Controller states; codes are visible on dbg_state.
  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX_R = 4'd2,
    S_WB_R = 4'd3,
    S_EX_I = 4'd4,
    S_WB_I = 4'd5,
    S_MA   = 4'd6,
    S_MR   = 4'd7,
    S_WBL  = 4'd8,
    S_MW   = 4'd9,
    S_BEQ  = 4'd10,
    S_JMP  = 4'd11
  } state_t;

  // ALU operation codes driven on alu_ctr.
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Next-PC source select.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Every control output in one bundle so a state's settings read as a unit.
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       i_or_d;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_ctr;
    logic       illegal;
  } ctrl_t;

  // Signed arithmetic whose overflow must suppress the register write.
  function automatic logic traps_on_overflow(input logic [5:0] op,
                                             input logic [5:0] funct);
    return (op == OP_ADDI) ||
           ((op == OP_RTYPE) && ((funct == F_ADD) || (funct == F_SUB)));
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags whether
// the funct is one this controller supports.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctr,
  output logic       o_legal
);

  // Pure lookup; unsupported functs fall back to addu and clear o_legal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_alu_ctr = ALU_ADDU;
    o_legal   = 1'b1;
    case (i_funct)
      F_ADDU:  o_alu_ctr = ALU_ADDU;
      F_ADD:   o_alu_ctr = ALU_ADD;
      F_SUBU:  o_alu_ctr = ALU_SUBU;
      F_SUB:   o_alu_ctr = ALU_SUB;
      F_OR:    o_alu_ctr = ALU_OR;
      F_SLTU:  o_alu_ctr = ALU_SLTU;
      F_SLT:   o_alu_ctr = ALU_SLT;
      default: o_legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. Steps each instruction through fetch,
// decode, execute, memory and write-back states, driving the datapath
// selects/enables and the ALU operation. Outputs are decoded from the
// state, with a few enables qualified by mem_ready, zero or the captured
// overflow flag.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic               ir_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               i_or_d,
  output logic               reg_wr,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [2:0]         alu_ctr,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  state_t r_state;
  state_t w_next;
  logic   r_ovf;
  ctrl_t  w_ctrl;
  logic [2:0] w_r_alu_ctr;
  logic       w_r_legal;

  mc_alu_dec u_alu_dec (
    .i_funct   (funct),
    .o_alu_ctr (w_r_alu_ctr),
    .o_legal   (w_r_legal)
  );

  // State register; synchronous reset returns to fetch.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  // Overflow flag: captured at the end of either execute state, cleared on
  // the way back to fetch, so it only ever qualifies the following WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_EX_R) || (r_state == S_EX_I)) begin
      r_ovf <= overflow && traps_on_overflow(op, funct);
    end else if (w_next == S_IF) begin
      r_ovf <= 1'b0;
    end
  end

  // Next state and control outputs from the current state.
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_IF: begin
        w_ctrl.mem_rd    = 1'b1;
        w_ctrl.i_or_d    = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_ctr   = ALU_ADDU;
        w_ctrl.pc_src    = PC_SRC_ALU;
        if (mem_ready) begin
          w_ctrl.pc_wr = 1'b1;
          w_ctrl.ir_wr = 1'b1;
          w_next       = S_ID;
        end
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.ext_op    = 1'b1;
        w_ctrl.alu_ctr   = ALU_ADDU;
        case (op)
          OP_RTYPE: begin
            if (w_r_legal) begin
              w_next = S_EX_R;
            end else begin
              w_ctrl.illegal = 1'b1;
              w_next         = S_IF;
            end
          end
          OP_ADDI, OP_ADDIU, OP_ORI: w_next = S_EX_I;
          OP_LW, OP_SW:              w_next = S_MA;
          OP_BEQ:                    w_next = S_BEQ;
          OP_J:                      w_next = S_JMP;
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next         = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_ctr   = w_r_alu_ctr;
        w_next           = S_WB_R;
      end
      S_WB_R: begin
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_wr     = ~r_ovf;
        w_next            = S_IF;
      end
      S_EX_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        case (op)
          OP_ORI: begin
            w_ctrl.ext_op  = 1'b0;
            w_ctrl.alu_ctr = ALU_OR;
          end
          OP_ADDI: begin
            w_ctrl.ext_op  = 1'b1;
            w_ctrl.alu_ctr = ALU_ADD;
          end
          default: begin
            w_ctrl.ext_op  = 1'b1;
            w_ctrl.alu_ctr = ALU_ADDU;
          end
        endcase
        w_next = S_WB_I;
      end
      S_WB_I: begin
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.reg_wr     = ~r_ovf;
        w_next            = S_IF;
      end
      S_MA: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_op    = 1'b1;
        w_ctrl.alu_ctr   = ALU_ADDU;
        w_next           = (op == OP_SW) ? S_MW : S_MR;
      end
      S_MR: begin
        w_ctrl.mem_rd = 1'b1;
        w_ctrl.i_or_d = 1'b1;
        if (mem_ready) w_next = S_WBL;
      end
      S_WBL: begin
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_wr     = 1'b1;
        w_next            = S_IF;
      end
      S_MW: begin
        w_ctrl.mem_wr = 1'b1;
        w_ctrl.i_or_d = 1'b1;
        if (mem_ready) w_next = S_IF;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_ctr   = ALU_SUBU;
        w_ctrl.pc_src    = PC_SRC_ALUOUT;
        w_ctrl.pc_wr     = zero;
        w_next           = S_IF;
      end
      S_JMP: begin
        w_ctrl.pc_src = PC_SRC_JUMP;
        w_ctrl.pc_wr  = 1'b1;
        w_next        = S_IF;
      end
      default: w_next = S_IF;
    endcase

    // Reset aborts whatever is in flight: no write of any kind on that edge.
    if (rst) begin
      w_ctrl.pc_wr   = 1'b0;
      w_ctrl.ir_wr   = 1'b0;
      w_ctrl.mem_rd  = 1'b0;
      w_ctrl.mem_wr  = 1'b0;
      w_ctrl.reg_wr  = 1'b0;
      w_ctrl.illegal = 1'b0;
    end
  end

  assign pc_wr      = w_ctrl.pc_wr;
  assign pc_src     = w_ctrl.pc_src;
  assign ir_wr      = w_ctrl.ir_wr;
  assign mem_rd     = w_ctrl.mem_rd;
  assign mem_wr     = w_ctrl.mem_wr;
  assign i_or_d     = w_ctrl.i_or_d;
  assign reg_wr     = w_ctrl.reg_wr;
  assign reg_dst    = w_ctrl.reg_dst;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign ext_op     = w_ctrl.ext_op;
  assign alu_ctr    = w_ctrl.alu_ctr;
  assign illegal    = w_ctrl.illegal;
  assign dbg_state  = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes the expected output vector
// for each cycle; a monitor on the falling edge pops and compares.
module tb_mc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       i_or_d;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_ctr;
    logic       illegal;
  } vec_t;

  typedef struct {
    vec_t  v;
    string name;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic       pc_wr, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst;
  logic       mem_to_reg, alu_src_a, ext_op, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctr;
  logic [3:0] dbg_state;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  mc_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .overflow   (overflow),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .ir_wr      (ir_wr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .i_or_d     (i_or_d),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_ctr    (alu_ctr),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Hand-written per-state settings; qualified enables are left 0 here and
  // set explicitly by each directed sequence.
  function automatic vec_t base(input logic [3:0] st);
    vec_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mem_rd = 1'b1; e.alu_src_b = 2'b01; end
      4'd1:  begin e.alu_src_b = 2'b11; e.ext_op = 1'b1; end
      4'd2:  begin e.alu_src_a = 1'b1; end
      4'd3:  begin e.reg_dst = 1'b1; end
      4'd4:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd6:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_op = 1'b1; end
      4'd7:  begin e.mem_rd = 1'b1; e.i_or_d = 1'b1; end
      4'd8:  begin e.mem_to_reg = 1'b1; e.reg_wr = 1'b1; end
      4'd9:  begin e.mem_wr = 1'b1; e.i_or_d = 1'b1; end
      4'd10: begin e.alu_src_a = 1'b1; e.alu_ctr = 3'b100; e.pc_src = 2'b01; end
      4'd11: begin e.pc_src = 2'b10; e.pc_wr = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: compare whatever the DUT presents this cycle with the oldest
  // expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        sb_item_t it;
        vec_t act;
        it  = sb_q.pop_front();
        act = {dbg_state, pc_wr, pc_src, ir_wr, mem_rd, mem_wr, i_or_d,
               reg_wr, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
               alu_ctr, illegal};
        checks++;
        if (act !== it.v) begin
          errors++;
          $display("FAIL %s: got %b expected %b (st/pcwr/pcsrc/irwr/rd/wr/iod/regwr/dst/m2r/a/b/ext/ctr/ill)",
                   it.name, act, it.v);
        end
      end
    end
  end

  // One clock of stimulus with its expected outputs.
  task automatic cyc(input vec_t e, input logic mr, input logic z,
                     input logic ov, input string nm);
    mem_ready = mr;
    zero      = z;
    overflow  = ov;
    sb_q.push_back('{v: e, name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits, input string nm);
    vec_t e;
    e = base(4'd0);
    for (int i = 0; i < waits; i++) cyc(e, 1'b0, 1'b0, 1'b0, {nm, "_if_wait"});
    e.pc_wr = 1'b1;
    e.ir_wr = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0, {nm, "_if"});
  endtask

  task automatic decode(input string nm);
    cyc(base(4'd1), 1'b1, 1'b0, 1'b0, {nm, "_id"});
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [2:0] ctr,
                       input logic ov, input logic wr, input string nm);
    vec_t e;
    op = 6'b000000; funct = fn;
    fetch(0, nm);
    decode(nm);
    e = base(4'd2); e.alu_ctr = ctr;
    cyc(e, 1'b1, 1'b0, ov, {nm, "_ex_r"});
    e = base(4'd3); e.reg_wr = wr;
    cyc(e, 1'b1, 1'b0, 1'b0, {nm, "_wb_r"});
  endtask

  task automatic run_i(input logic [5:0] opc, input logic ext,
                       input logic [2:0] ctr, input logic ov, input logic wr,
                       input string nm);
    vec_t e;
    op = opc; funct = 6'b000000;
    fetch(0, nm);
    decode(nm);
    e = base(4'd4); e.ext_op = ext; e.alu_ctr = ctr;
    cyc(e, 1'b1, 1'b0, ov, {nm, "_ex_i"});
    e = base(4'd5); e.reg_wr = wr;
    cyc(e, 1'b1, 1'b0, 1'b0, {nm, "_wb_i"});
  endtask

  task automatic run_beq(input logic z, input string nm);
    vec_t e;
    op = 6'b000100; funct = 6'b000000;
    fetch(0, nm);
    decode(nm);
    e = base(4'd10); e.pc_wr = z;
    cyc(e, 1'b1, z, 1'b0, {nm, "_beq"});
  endtask

  task automatic run_illegal(input logic [5:0] opc, input logic [5:0] fn,
                             input string nm);
    vec_t e;
    op = opc; funct = fn;
    fetch(0, nm);
    e = base(4'd1); e.illegal = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0, {nm, "_id_illegal"});
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Held in reset: state IF, every enable suppressed.
    e = base(4'd0); e.mem_rd = 1'b0;
    cyc(e, 1'b1, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // R-type: addu, overflow gating for add/sub, remaining ALU codes.
    run_r(6'b100001, 3'b000, 1'b0, 1'b1, "addu");
    run_r(6'b100000, 3'b001, 1'b1, 1'b0, "add_ovf");
    run_r(6'b100001, 3'b000, 1'b1, 1'b1, "addu_ovf");
    run_r(6'b100010, 3'b101, 1'b1, 1'b0, "sub_ovf");
    run_r(6'b100011, 3'b100, 1'b0, 1'b1, "subu");
    run_r(6'b100101, 3'b010, 1'b0, 1'b1, "or");
    run_r(6'b101010, 3'b111, 1'b0, 1'b1, "slt");
    run_r(6'b101011, 3'b110, 1'b0, 1'b1, "sltu");

    // I-type ALU ops.
    run_i(6'b001101, 1'b0, 3'b010, 1'b0, 1'b1, "ori");
    run_i(6'b001000, 1'b1, 3'b001, 1'b1, 1'b0, "addi_ovf");
    run_i(6'b001001, 1'b1, 3'b000, 1'b1, 1'b1, "addiu_ovf");
    run_i(6'b001000, 1'b1, 3'b001, 1'b0, 1'b1, "addi");

    // lw with three wait cycles in both fetch and memory read (11 cycles).
    op = 6'b100011; funct = 6'b000000;
    fetch(3, "lw");
    decode("lw");
    cyc(base(4'd6), 1'b1, 1'b0, 1'b0, "lw_ma");
    for (int i = 0; i < 3; i++) cyc(base(4'd7), 1'b0, 1'b0, 1'b0, "lw_mr_wait");
    cyc(base(4'd7), 1'b1, 1'b0, 1'b0, "lw_mr");
    cyc(base(4'd8), 1'b1, 1'b0, 1'b0, "lw_wbl");

    // Branches taken and not taken, then jump.
    run_beq(1'b1, "beq_taken");
    run_beq(1'b0, "beq_not_taken");
    op = 6'b000010;
    fetch(0, "j");
    decode("j");
    cyc(base(4'd11), 1'b1, 1'b0, 1'b0, "j_jmp");

    // Unsupported opcode and unsupported R-type funct.
    run_illegal(6'b111111, 6'b000000, "bad_op");
    run_illegal(6'b000000, 6'b000000, "bad_funct");

    // sw stalled in MW, then reset lands mid-store.
    op = 6'b101011;
    fetch(0, "sw_rst");
    decode("sw_rst");
    cyc(base(4'd6), 1'b1, 1'b0, 1'b0, "sw_rst_ma");
    cyc(base(4'd9), 1'b0, 1'b0, 1'b0, "sw_rst_mw_wait");
    rst = 1'b1;
    e = base(4'd9); e.mem_wr = 1'b0;
    cyc(e, 1'b0, 1'b0, 1'b0, "rst_in_mw");
    e = base(4'd0); e.mem_rd = 1'b0;
    cyc(e, 1'b1, 1'b0, 1'b0, "rst_after_mw");
    rst = 1'b0;

    // Complete sw without stalls: 4 cycles, back to IF.
    fetch(0, "sw");
    decode("sw");
    cyc(base(4'd6), 1'b1, 1'b0, 1'b0, "sw_ma");
    cyc(base(4'd9), 1'b1, 1'b0, 1'b0, "sw_mw");
    e = base(4'd0); e.pc_wr = 1'b1; e.ir_wr = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0, "sw_back_to_if");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit: the initiator side of the ALU interface.
- Sequences every instruction through IF/ID/EX/MEM/WB.
- Drives alu_ctr and datapath mux/enable selects, and consumes the ALU's zero/overflow flags.
- Waits on a memory ready handshake; sits between IR/opcode decode and the datapath (ALU, regfile, PC, memory).

Parameters:
- STATE_W, 4, width of state register / dbg_state port

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU Z flag
- overflow  in  1  ALU Overflow flag
- mem_ready  in  1  memory completes current access this cycle
- pc_wr  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
- ir_wr  out  1  IR load enable
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- reg_wr  out  1  register file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_ctr  out  3  000 addu, 001 add, 010 or, 100 subu, 101 sub, 110 sltu, 111 slt
- illegal  out  1  one-cycle pulse on unsupported op/funct
- dbg_state  out  STATE_W  current state code

Behaviour:
- Reset: one clock with rst=1 puts the state in IF and clears ovf_q.
  - While rst=1, every enable output (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr) and illegal is 0.
  - Reset mid-instruction aborts it; nothing is written on that edge.
- Outputs are Moore (decoded from state), except:
  - pc_wr/ir_wr in IF, gated by mem_ready;
  - pc_wr in BEQ, gated by zero;
  - reg_wr in WB_R/WB_I, gated by ~ovf_q.
- Selects not listed for a state are 0. Enables not listed are 0.
- Supported instructions:
  - R-type (op=000000) funct: addu 100001, add 100000, subu 100011, sub 100010, or 100101, sltu 101011, slt 101010.
  - I-type: addi 001000, addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010.
- States and transitions:
  - IF (0): mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=addu. If mem_ready: pc_wr=1, pc_src=00, ir_wr=1, go to ID; else stay in IF.
  - ID (1): alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=addu (branch target into ALUOut). Next state by op:
    - R-type -> EX_R
    - addi/addiu/ori -> EX_I
    - lw/sw -> MA
    - beq -> BEQ
    - j -> JMP
    - anything else (or R-type with unsupported funct) -> illegal=1 for this cycle, next IF.
  - EX_R (2): alu_src_a=1, alu_src_b=00, alu_ctr from funct. Next WB_R.
  - WB_R (3): reg_dst=1, mem_to_reg=0, reg_wr=~ovf_q. Next IF.
  - EX_I (4): alu_src_a=1, alu_src_b=10, ext_op=0 for ori else 1; alu_ctr = or (ori), add (addi), addu (addiu). Next WB_I.
  - WB_I (5): reg_dst=0, mem_to_reg=0, reg_wr=~ovf_q. Next IF.
  - MA (6): alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctr=addu. Next MR (lw) or MW (sw).
  - MR (7): mem_rd=1, i_or_d=1. If mem_ready go to WBL, else stay.
  - WBL (8): reg_dst=0, mem_to_reg=1, reg_wr=1. Next IF.
  - MW (9): mem_wr=1, i_or_d=1. If mem_ready go to IF, else stay.
  - BEQ (10): alu_src_a=1, alu_src_b=00, alu_ctr=subu, pc_src=01, pc_wr=zero. Next IF.
  - JMP (11): pc_src=10, pc_wr=1. Next IF.
- Overflow register ovf_q:
  - Captured at the end of EX_R and EX_I as overflow AND (op is add, sub or addi). For all other ops it is captured as 0.
  - Cleared on entry to IF.
  - Overflowing add/sub/addi therefore never writes the register file.
- Latency (cycles with mem_ready=1 throughout): R-type 4, I-ALU 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each memory wait cycle adds 1 cycle. mem_rd/mem_wr stay asserted and stable until mem_ready is seen.

Decomposition:
- Package mc_pkg holds:
  - state encodings (S_IF..S_JMP);
  - ALUctr encodings (ALU_ADDU..ALU_SLT), shared with the ALU;
  - op/funct constants;
  - pc_src/alu_src_b select constants.
- One sub-module: mc_alu_dec (combinational funct -> alu_ctr for R-type, plus legality flag). Used by EX_R and by ID's illegal check.

Test Plan:
- Reset then addu (op=0, funct=100001), mem_ready=1: states 0,1,2,3,0; pc_wr=1 and ir_wr=1 in IF; alu_ctr=000 in EX_R; reg_wr=1, reg_dst=1 in WB_R.
- add with overflow=1 in EX_R: WB_R has reg_wr=0. Same with addu, overflow=1: WB_R has reg_wr=1.
- lw with mem_ready low for 3 cycles in both IF and MR: IF held 4 cycles with mem_rd=1, pc_wr=0 until ready; MR held 4 cycles; WBL has mem_to_reg=1, reg_wr=1; total 11 cycles.
- beq with zero=1: BEQ has pc_wr=1, pc_src=01, alu_ctr=100. Repeat with zero=0: pc_wr=0. Both take 3 cycles.
- ori: EX_I has ext_op=0, alu_ctr=010. slt/sltu R-type: alu_ctr 111/110. j: JMP has pc_src=10, pc_wr=1.
- op=111111 -> illegal pulses 1 cycle in ID, next state IF. rst asserted in MW with mem_wr=1 -> next cycle state 0, all enables 0.
